zx8x_tape_player: RTL and testbench
===================================

// Module: zx8x_tape_player
// PURPOSE
//  Replays a tape image held in the tape buffer as a real-time ZX80/ZX81 cassette signal.
//  It sits upstream of the machine's tape input: tape_out drives the ULA EAR bit (tape_in)
//  in place of UART_RX, so an unpatched ROM LOAD routine reads the image at native speed.
//  It emits one synthetic name byte, then tape_len bytes read from the buffer.
//  Each byte is sent MSB first as ZX81 pulse trains: bit0 = 4 pulses, bit1 = 9 pulses,
//  and every bit is followed by a silence gap.
// PARAMETERS
//  ADDR_W     14      tape buffer address width (16 KB buffer)
//  T_HALF     975     ce ticks per pulse half-period (150 us at 6.5 MHz ce)
//  T_GAP      8450    ce ticks of silence after each bit (1300 us)
//  T_LEADER   3250000 ce ticks of silence before the first byte (0.5 s)
//  NAME_BYTE  8'hA6   synthetic file name byte ('A' with end-of-name bit7 set)
// PORTS
//  clk_sys    in   1       system clock (52 MHz)
//  reset_n    in   1       asynchronous reset, active low
//  ce         in   1       timing tick (ce_65); all timers count only on ce=1
//  start      in   1       1-clk request to begin playback; ignored while busy=1
//  stop       in   1       1-clk abort; returns to IDLE
//  tape_len   in   ADDR_W  number of image bytes; sampled on accepted start
//  mem_addr   out  ADDR_W  buffer read address
//  mem_data   in   8       buffer read data, valid the 2nd clk after mem_addr changes
//  tape_out   out  1       cassette level: 1 = pulse high, 0 = low or silence
//  busy       out  1       high from accepted start until playback ends
//  done       out  1       1-clk pulse on normal completion; no pulse on stop
// BEHAVIOUR
//  Reset values: tape_out=0, busy=0, done=0, mem_addr=0. State is IDLE and all counters are 0.
//  States: IDLE, LEADER, FETCH, PULSE_HI, PULSE_LO, GAP, FINISH.
//  IDLE:
//   - start=1: latch len=tape_len, set idx=0, busy<=1, sel_name<=1, go to LEADER.
//  LEADER:
//   - tape_out=0; count T_LEADER ce ticks, then go to FETCH.
//  FETCH:
//   - If sel_name=1, shreg<=NAME_BYTE immediately.
//   - Otherwise, on FETCH entry mem_addr<=idx; two clk later shreg<=mem_data.
//   - Set bitcnt=7, then go to PULSE_HI with pcnt = 4 or 9 from shreg[7].
//  PULSE_HI:
//   - tape_out=1 for T_HALF ticks, then PULSE_LO.
//  PULSE_LO:
//   - tape_out=0 for T_HALF ticks; then pcnt--.
//   - If pcnt is still nonzero, go to PULSE_HI; else go to GAP.
//  GAP:
//   - tape_out=0 for T_GAP ticks.
//   - If bitcnt!=0: bitcnt--, shreg<<=1, go to PULSE_HI with the count of the new MSB.
//   - Else, byte done: if sel_name, clear it; otherwise idx++.
//   - Then go to FETCH if idx<len, else go to FINISH.
//  FINISH:
//   - done<=1 for one clk, busy<=0, go to IDLE.
//  Counters load with (period-1) on state entry and transition when they reach 0 on a ce tick.
//  A half-period therefore lasts exactly T_HALF ce ticks.
//  FETCH timing is in clk, not ce. A FETCH stall never shortens or extends a gap by more than 3 clk.
//  tape_len=0: play the leader and the name byte only, then FINISH.
//  Max len is 2^ADDR_W-1. idx is ADDR_W bits; idx==len terminates before wrap.
//  stop=1 in any state: next clk IDLE, tape_out=0, busy=0, done=0. Stop has priority over start.
//  start while busy: ignored. A change of tape_len while busy has no effect.
//  reset_n low mid-playback: immediate return to reset values. No done pulse.
//  Bit durations: bit0 = 8*T_HALF+T_GAP ticks; bit1 = 18*T_HALF+T_GAP ticks.
// TESTING
//  (params T_HALF=2, T_GAP=10, T_LEADER=20, ce=1 every clk unless noted)
//  1. start with len=0: 20 low ticks, then NAME_BYTE 0xA6 (bits 1,0,1,0,0,1,1,0).
//     Expect pulse counts 9,4,9,4,4,9,9,4. Then done 1 clk, busy=0.
//  2. Buffer[0]=0xFF, len=1: after the name, 8 bits of 9 pulses each.
//     Each high lasts exactly 2 ticks; each gap is 10 ticks. mem_addr=0 is read once.
//  3. len=3 with bytes 0x00,0x80,0x01: mem_addr steps 0,1,2.
//     Expect 0x80 to give 9 then 7x4 pulses and 0x01 to give 7x4 then 9 pulses.
//  4. Pulse stop during PULSE_HI of byte 2: next clk tape_out=0, busy=0, done never asserts.
//     A subsequent start replays from the name.
//  5. ce asserted 1 clk in 8: a tape_out high lasts 16 clk; timing scales with ce only.
//  6. Drop reset_n asynchronously during GAP: outputs return to 0 at once.
//     A start issued while busy is ignored, with no restart of the leader.

Source files
------------

// File: rtl/zx8x_tape_player_if.sv
// Tape buffer read port of the ZX80/ZX81 tape player.
// The player drives the address; the buffer answers two clocks later.
interface zx8x_tape_player_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    output mem_addr,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    output mem_data
  );
endinterface

// File: rtl/zx8x_tape_player.sv
// ZX80/ZX81 cassette replay: leader, one name byte, then tape_len buffer
// bytes, each bit sent MSB first as 4 or 9 pulses plus a silence gap.
module zx8x_tape_player #(
  parameter int         ADDR_W    = 14,
  parameter int         T_HALF    = 975,
  parameter int         T_GAP     = 8450,
  parameter int         T_LEADER  = 3250000,
  parameter logic [7:0] NAME_BYTE = 8'hA6
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] tape_len,
  zx8x_tape_player_if.master mem,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  localparam int P1    = (T_LEADER > T_GAP) ? T_LEADER : T_GAP;
  localparam int P2    = (P1 > T_HALF) ? P1 : T_HALF;
  localparam int CNT_W = $clog2(P2 + 4);

  localparam logic [CNT_W-1:0] C_LEAD  = CNT_W'(T_LEADER - 1);
  localparam logic [CNT_W-1:0] C_HALF  = CNT_W'(T_HALF - 1);
  localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] C_FETCH = CNT_W'(2);

  typedef enum logic [2:0] {
    IDLE, LEADER, FETCH, PULSE_HI,
    PULSE_LO, GAP, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_nx;
  logic              sel_q, sel_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        fetch_b;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [3:0]        pcnt_q, pcnt_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              zero;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      sel_q    <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      pcnt_q   <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      pcnt_q   <= pcnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pcnt_d   = pcnt_q;
    idx_nx   = idx_q;
    zero     = (cnt_q == '0);
    fetch_b  = sel_q ? NAME_BYTE : mem.mem_data;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = tape_len;
          idx_d   = '0;
          sel_d   = 1'b1;
          cnt_d   = C_LEAD;
          state_d = LEADER;
        end
      end
      LEADER: begin
        if (ce && zero) begin
          cnt_d   = C_FETCH;
          state_d = FETCH;
        end else if (ce) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Buffer bytes wait out the two-clock read latency; ce plays no part.
      FETCH: begin
        if (sel_q || zero) begin
          shreg_d  = fetch_b;
          bitcnt_d = 3'd7;
          pcnt_d   = fetch_b[7] ? 4'd9 : 4'd4;
          cnt_d    = C_HALF;
          state_d  = PULSE_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE_HI: begin
        if (ce && zero) begin
          cnt_d   = C_HALF;
          state_d = PULSE_LO;
        end else if (ce) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE_LO: begin
        if (ce && zero) begin
          pcnt_d = pcnt_q - 1'b1;
          if (pcnt_q != 4'd1) begin
            cnt_d   = C_HALF;
            state_d = PULSE_HI;
          end else begin
            cnt_d   = C_GAP;
            state_d = GAP;
          end
        end else if (ce) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (ce && zero) begin
          if (bitcnt_q != 3'd0) begin
            bitcnt_d = bitcnt_q - 1'b1;
            shreg_d  = {shreg_q[6:0], 1'b0};
            pcnt_d   = shreg_q[6] ? 4'd9 : 4'd4;
            cnt_d    = C_HALF;
            state_d  = PULSE_HI;
          end else begin
            if (sel_q) sel_d = 1'b0;
            else       idx_nx = idx_q + 1'b1;
            idx_d = idx_nx;
            if (idx_nx < len_q) begin
              addr_d  = idx_nx;
              cnt_d   = C_FETCH;
              state_d = FETCH;
            end else begin
              state_d = FINISH;
            end
          end
        end else if (ce) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
    out_d  = (state_d == PULSE_HI);
    busy_d = (state_d != IDLE);
    done_d = (state_q == FINISH) && !stop;
  end

  assign mem.mem_addr = addr_q;
  assign tape_out     = out_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_zx8x_tape_player.sv
// Bench for zx8x_tape_player: per-clock waveform model built from the
// bit/pulse/gap rules, plus literal pulse and busy-length totals.
module tb_zx8x_tape_player;
  localparam int AW = 14;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b1;
  logic          ce = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] tape_len = '0;
  logic          tape_out, busy, done;
  logic [7:0]    mem [16];
  logic [7:0]    d1;

  zx8x_tape_player_if #(.ADDR_W(AW)) mif();

  zx8x_tape_player #(
    .ADDR_W(AW), .T_HALF(2), .T_GAP(10),
    .T_LEADER(20), .NAME_BYTE(8'hA6)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .start   (start),
    .stop    (stop),
    .tape_len(tape_len),
    .mem     (mif),
    .tape_out(tape_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk_sys = ~clk_sys;

  // Buffer with two clocks of read latency.
  always @(posedge clk_sys) begin
    d1           <= mem[mif.mem_addr[3:0]];
    mif.mem_data <= d1;
  end

  int checks = 0;
  int failures = 0;
  bit idle_chk = 1;
  bit ce_slow = 0;
  int cyc = 0;
  int rises = 0, busy_cnt = 0, done_cnt = 0;
  logic prev_to = 1'b0;

  typedef struct {
    bit          to;
    bit          bz;
    bit          dn;
    bit          ca;
    logic [AW-1:0] a;
    int          bi;
    bit          gp;
  } exp_t;
  exp_t q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(bit to, bit bz, bit dn, bit ca,
                      int a, int bi, bit gp, int n);
    exp_t e;
    e.to = to; e.bz = bz; e.dn = dn; e.ca = ca;
    e.a = AW'(a); e.bi = bi; e.gp = gp;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Expected per-clock outputs for a run starting the clock after start.
  task automatic build(int len);
    logic [7:0] b;
    push(0, 1, 0, 0, 0, -1, 0, 20);
    for (int k = 0; k <= len; k++) begin
      if (k == 0) begin
        b = 8'hA6;
        push(0, 1, 0, 0, 0, 0, 0, 1);
      end else begin
        b = mem[k-1];
        push(0, 1, 0, 1, k-1, k, 0, 3);
      end
      for (int j = 7; j >= 0; j--) begin
        int n;
        n = b[j] ? 9 : 4;
        for (int p = 0; p < n; p++) begin
          push(1, 1, 0, 0, 0, k, 0, 2);
          push(0, 1, 0, 0, 0, k, 0, 2);
        end
        push(0, 1, 0, 0, 0, k, 1, 10);
      end
    end
    push(0, 1, 0, 0, 0, -2, 0, 1);
    push(0, 0, 1, 0, 0, -2, 0, 1);
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tape_out", tape_out, e.to);
        chk("busy", busy, e.bz);
        chk("done", done, e.dn);
        if (e.ca) chk("mem_addr", mif.mem_addr, e.a);
      end else if (idle_chk) begin
        chk("idle_out", {tape_out, busy, done}, 3'b000);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk_sys);
      if (tape_out === 1'b1 && prev_to === 1'b0) rises++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      prev_to = tape_out;
    end
  end

  initial begin : ce_gen
    forever begin
      @(posedge clk_sys);
      #1;
      cyc++;
      ce = ce_slow ? (cyc % 8 == 0) : 1'b1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic clr_cnt();
    rises = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic do_start(int len, bit mk);
    @(posedge clk_sys);
    #1;
    tape_len = AW'(len);
    start = 1'b1;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    if (mk) build(len);
  endtask

  task automatic wait_done(string nm, int bound);
    int n;
    n = 0;
    while (q.size() > 0 && n < bound) begin
      @(posedge clk_sys);
      n++;
    end
    if (q.size() > 0) begin
      chk({nm, "_timeout"}, q.size(), 0);
      q.delete();
    end
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk_sys);
    #1;
    stop = 1'b0;
    q.delete();
  endtask

  initial begin : driver
    int n, lo, hi;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_tape_out", tape_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // 1: name byte only
    clr_cnt();
    do_start(0, 1);
    wait_done("t1", 1000);
    chk("t1_pulses", rises, 52);
    chk("t1_busy_len", busy_cnt, 310);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: one 0xFF byte
    mem[0] = 8'hFF;
    clr_cnt();
    do_start(1, 1);
    wait_done("t2", 2000);
    chk("t2_pulses", rises, 124);
    chk("t2_busy_len", busy_cnt, 681);

    // 3: three bytes; start and tape_len change while busy are ignored
    mem[0] = 8'h00; mem[1] = 8'h80; mem[2] = 8'h01;
    clr_cnt();
    do_start(3, 1);
    repeat (40) @(posedge clk_sys);
    #1;
    tape_len = '0;
    start = 1'b1;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    wait_done("t3", 3000);
    chk("t3_pulses", rises, 158);
    chk("t3_busy_len", busy_cnt, 983);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: stop during a high pulse of the second buffer byte
    clr_cnt();
    do_start(3, 1);
    n = 0;
    while (!(q.size() > 0 && q[0].bi == 2 && q[0].to) && n < 3000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    chk("t4_reach", (n < 3000), 1'b1);
    pulse_stop();
    repeat (20) @(posedge clk_sys);
    #1;
    chk("t4_done_cnt", done_cnt, 0);
    clr_cnt();
    do_start(0, 1);
    wait_done("t4b", 1000);
    chk("t4_replay_pulses", rises, 52);

    // 5: ce one clock in eight
    idle_chk = 0;
    ce_slow = 1;
    do_start(0, 0);
    n = 0;
    while (tape_out !== 1'b1 && n < 3000) begin @(negedge clk_sys); n++; end
    while (tape_out === 1'b1 && n < 3000) begin @(negedge clk_sys); n++; end
    lo = 0;
    while (tape_out === 1'b0 && n < 3000) begin @(negedge clk_sys); lo++; n++; end
    hi = 0;
    while (tape_out === 1'b1 && n < 3000) begin @(negedge clk_sys); hi++; n++; end
    chk("t5_lo_clk", lo, 16);
    chk("t5_hi_clk", hi, 16);
    @(posedge clk_sys);
    #1;
    pulse_stop();
    ce_slow = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("t5_stopped", {tape_out, busy, done}, 3'b000);
    idle_chk = 1;

    // 6: asynchronous reset during a gap of the second buffer byte
    mem[0] = 8'h5A; mem[1] = 8'hC3;
    clr_cnt();
    do_start(2, 1);
    n = 0;
    while (!(q.size() > 0 && q[0].bi == 2 && q[0].gp) && n < 3000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    chk("t6_reach", (n < 3000), 1'b1);
    chk("t6_addr_before", mif.mem_addr, 1);
    #1 reset_n = 1'b0;
    q.delete();
    #1;
    chk("t6_rst_out", {tape_out, busy, done}, 3'b000);
    chk("t6_rst_addr", mif.mem_addr, 0);
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("t6_done_cnt", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
